// File: rtl/arc4_pkg.sv
// Shared ARC4 datapath types: S-array geometry, byte type and the KSA state encoding.
package arc4_pkg;

   localparam int unsigned S_SIZE         = 256;
   localparam int unsigned KEY_BYTES_DFLT = 3;
   localparam int unsigned BYTE_W         = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_I,
      CAP_I,
      RD_J,
      CAP_J,
      WR_I,
      WR_J
   } ksa_state_t;

endpackage

// File: rtl/ksa_if.sv
// Start/ready handshake, cipher key and S-memory port of the key-scheduling stage.
interface ksa_if #(
   parameter int unsigned KEY_BYTES = arc4_pkg::KEY_BYTES_DFLT
);
   import arc4_pkg::*;

   logic                   en;
   logic                   rdy;
   logic [8*KEY_BYTES-1:0] key;
   byte_t                  addr;
   byte_t                  rddata;
   byte_t                  wrdata;
   logic                   wren;

   modport master (
      input  en,
      input  key,
      input  rddata,
      output rdy,
      output addr,
      output wrdata,
      output wren
   );

   modport slave (
      output en,
      output key,
      output rddata,
      input  rdy,
      input  addr,
      input  wrdata,
      input  wren
   );

endinterface

// File: rtl/ksa.sv
// ARC4 key-scheduling loop run in place over an external 256x8 S memory with
// synchronous read; six cycles per iteration (read i, read j, write i, write j).
module ksa #(
   parameter int unsigned KEY_BYTES = arc4_pkg::KEY_BYTES_DFLT,
   parameter int unsigned S_SIZE    = arc4_pkg::S_SIZE
) (
   input  logic  clk,
   input  logic  rst,
   ksa_if.master bus
);
   import arc4_pkg::*;

   localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam byte_t       LAST_I = byte_t'(S_SIZE - 1);

   ksa_state_t        state_q, state_d;
   byte_t             i_q, i_d;
   byte_t             j_q, j_d;
   byte_t             si_q, si_d;
   byte_t             sj_q, sj_d;
   logic [KIDX_W-1:0] kidx_q, kidx_d;
   logic [KIDX_W-1:0] kidx_inc;
   byte_t             key_byte;

   byte_t             addr_q, addr_d;
   byte_t             wrdata_q, wrdata_d;
   logic              wren_q, wren_d;
   logic              rdy_q, rdy_d;

   // Key byte select: byte 0 is the most significant byte of the key.
   always_comb begin
      key_byte = byte_t'(bus.key >> (8 * (KEY_BYTES - 1 - 32'(kidx_q))));
      kidx_inc = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
   end

   // Next-state and datapath update; outputs are decoded from the next state
   // so the registered outputs track the state register without lag.
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      si_d     = si_q;
      sj_d     = sj_q;
      kidx_d   = kidx_q;
      addr_d   = '0;
      wrdata_d = '0;
      wren_d   = 1'b0;
      rdy_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.en) begin
               i_d     = '0;
               j_d     = '0;
               kidx_d  = '0;
               state_d = RD_I;
            end
         end
         RD_I:  state_d = CAP_I;
         CAP_I: begin
            si_d    = bus.rddata;
            j_d     = j_q + bus.rddata + key_byte;
            state_d = RD_J;
         end
         RD_J:  state_d = CAP_J;
         CAP_J: begin
            sj_d    = bus.rddata;
            state_d = WR_I;
         end
         WR_I:  state_d = WR_J;
         WR_J: begin
            i_d     = i_q + 8'd1;
            kidx_d  = kidx_inc;
            state_d = (i_q == LAST_I) ? IDLE : RD_I;
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         IDLE:        rdy_d  = 1'b1;
         RD_I, CAP_I: addr_d = i_d;
         RD_J, CAP_J: addr_d = j_d;
         WR_I: begin
            addr_d   = i_d;
            wrdata_d = sj_d;
            wren_d   = 1'b1;
         end
         WR_J: begin
            addr_d   = j_d;
            wrdata_d = si_d;
            wren_d   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         i_q      <= '0;
         j_q      <= '0;
         si_q     <= '0;
         sj_q     <= '0;
         kidx_q   <= '0;
         addr_q   <= '0;
         wrdata_q <= '0;
         wren_q   <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         si_q     <= si_d;
         sj_q     <= sj_d;
         kidx_q   <= kidx_d;
         addr_q   <= addr_d;
         wrdata_q <= wrdata_d;
         wren_q   <= wren_d;
         rdy_q    <= rdy_d;
      end
   end

   assign bus.addr   = addr_q;
   assign bus.wrdata = wrdata_q;
   assign bus.wren   = wren_q;
   assign bus.rdy    = rdy_q;

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: synchronous-read S memory model, write log and a
// plain software ARC4 key schedule as reference.
module tb_ksa;
   import arc4_pkg::*;

   localparam int unsigned KB = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ksa_if #(.KEY_BYTES(KB)) bus ();

   ksa #(.KEY_BYTES(KB), .S_SIZE(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   byte_t mem   [256];
   byte_t ref_s [256];

   int    cyc      = 0;
   int    acc_n    = 0;
   int    acc_cyc  = 0;
   int    acc_q [$];
   int    rises    = 0;
   int    rise_cyc = 0;
   int    low_run  = 0;
   int    last_low = 0;
   logic  rdy_prev = 1'b1;
   int    wcyc [$];
   byte_t wa [$];
   byte_t wd [$];

   int    n_vec = 0;
   int    n_err = 0;

   // Memory model and edge monitor
   always @(posedge clk) begin
      cyc = cyc + 1;
      bus.rddata <= mem[bus.addr];
      if (bus.wren === 1'b1) begin
         mem[bus.addr] = bus.wrdata;
         wcyc.push_back(cyc);
         wa.push_back(bus.addr);
         wd.push_back(bus.wrdata);
      end
      if (bus.rdy !== 1'b1) low_run = low_run + 1;
      if (bus.rdy === 1'b1 && rdy_prev !== 1'b1) begin
         rises    = rises + 1;
         rise_cyc = cyc;
         last_low = low_run;
      end
      if (bus.en === 1'b1 && bus.rdy === 1'b1) begin
         acc_n   = acc_n + 1;
         acc_cyc = cyc;
         acc_q.push_back(cyc);
         low_run = 0;
      end
      rdy_prev = bus.rdy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_init();
      for (int i = 0; i < 256; i++) ref_s[i] = byte_t'(i);
   endfunction

   function automatic void ref_ksa(input logic [23:0] k);
      int    j;
      int    kb;
      byte_t t;
      j = 0;
      for (int i = 0; i < 256; i++) begin
         kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
         j  = (j + int'(ref_s[i]) + kb) % 256;
         t        = ref_s[i];
         ref_s[i] = ref_s[j];
         ref_s[j] = t;
      end
   endfunction

   task automatic mem_identity();
      for (int i = 0; i < 256; i++) mem[i] = byte_t'(i);
   endtask

   task automatic clr_log();
      wcyc.delete();
      wa.delete();
      wd.delete();
   endtask

   task automatic start_run(input logic [23:0] k);
      @(negedge clk);
      bus.key = k;
      bus.en  = 1'b1;
      @(negedge clk);
      bus.en  = 1'b0;
   endtask

   task automatic wait_done(input int prev, input string tag);
      int n;
      n = 0;
      while (rises == prev && n < 3000) begin
         @(negedge clk);
         n = n + 1;
      end
      chk({tag, "_done"}, 32'(rises != prev), 32'd1);
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 256; i++) chk(tag, 32'(mem[i]), 32'(ref_s[i]));
   endtask

   task automatic check_timing(input string tag);
      chk({tag, "_rise"}, 32'(rise_cyc - acc_cyc), 32'd1537);
      chk({tag, "_low"},  32'(last_low), 32'd1536);
   endtask

   // Full identity-memory run with given key, checked against the reference
   task automatic full_run(input logic [23:0] k, input string tag);
      int r;
      int a;
      mem_identity();
      ref_init();
      clr_log();
      r = rises;
      a = acc_n;
      start_run(k);
      wait_done(r, tag);
      chk({tag, "_acc"}, 32'(acc_n - a), 32'd1);
      chk({tag, "_nwr"}, 32'(wa.size()), 32'd512);
      ref_ksa(k);
      check_mem({tag, "_mem"});
      check_timing(tag);
   endtask

   initial begin
      int    r;
      int    a;
      int    n;
      int    nw;
      logic [23:0] k;

      rst     = 1'b1;
      bus.en  = 1'b0;
      bus.key = '0;
      mem_identity();

      #2;
      chk("rst_rdy",    32'(bus.rdy),    32'd1);
      chk("rst_wren",   32'(bus.wren),   32'd0);
      chk("rst_addr",   32'(bus.addr),   32'd0);
      chk("rst_wrdata", 32'(bus.wrdata), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Key 010203: first two iterations' writes and their cycle positions
      full_run(24'h010203, "k010203");
      if (wa.size() >= 4) begin
         chk("k010203_w0a", 32'(wa[0]), 32'd0);
         chk("k010203_w0d", 32'(wd[0]), 32'h01);
         chk("k010203_w1a", 32'(wa[1]), 32'd1);
         chk("k010203_w1d", 32'(wd[1]), 32'h00);
         chk("k010203_w2a", 32'(wa[2]), 32'd1);
         chk("k010203_w2d", 32'(wd[2]), 32'h03);
         chk("k010203_w3a", 32'(wa[3]), 32'd3);
         chk("k010203_w3d", 32'(wd[3]), 32'h00);
         chk("k010203_w0cyc", 32'(wcyc[0] - acc_cyc), 32'd5);
         chk("k010203_w1cyc", 32'(wcyc[1] - acc_cyc), 32'd6);
         chk("k010203_w2cyc", 32'(wcyc[2] - acc_cyc), 32'd11);
      end

      // Key 0: iteration 0 has i == j
      full_run(24'h000000, "k000000");
      if (wa.size() >= 2) begin
         chk("k0_w0a", 32'(wa[0]), 32'd0);
         chk("k0_w0d", 32'(wd[0]), 32'd0);
         chk("k0_w1a", 32'(wa[1]), 32'd0);
         chk("k0_w1d", 32'(wd[1]), 32'd0);
      end

      full_run(24'h00033C, "k00033c");

      for (int t = 0; t < 3; t++) begin
         k = 24'($urandom);
         full_run(k, "krand");
      end

      // Pulse en mid-run: must be ignored
      mem_identity();
      ref_init();
      clr_log();
      k = 24'($urandom);
      r = rises;
      a = acc_n;
      start_run(k);
      while (cyc < acc_cyc + 499) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      wait_done(r, "enpulse");
      chk("enpulse_acc", 32'(acc_n - a), 32'd1);
      ref_ksa(k);
      check_mem("enpulse_mem");
      check_timing("enpulse");

      // Asynchronous reset mid-run
      mem_identity();
      clr_log();
      start_run(24'h5A5A5A);
      while (cyc < acc_cyc + 699) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_wren",   32'(bus.wren),   32'd0);
      chk("arst_rdy",    32'(bus.rdy),    32'd1);
      chk("arst_addr",   32'(bus.addr),   32'd0);
      chk("arst_wrdata", 32'(bus.wrdata), 32'd0);
      nw = wa.size();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("arst_nowr",    32'(wa.size()), 32'(nw));
      chk("arst_idlerdy", 32'(bus.rdy),   32'd1);
      full_run(24'hC0FFEE, "postrst");

      // Back-to-back: en held high across completion
      mem_identity();
      ref_init();
      clr_log();
      k = 24'($urandom);
      r = rises;
      a = acc_n;
      @(negedge clk);
      bus.key = k;
      bus.en  = 1'b1;
      n = 0;
      while (acc_n < a + 2 && n < 4000) begin
         @(negedge clk);
         n = n + 1;
      end
      bus.en = 1'b0;
      chk("b2b_acc", 32'(acc_n - a), 32'd2);
      n = 0;
      while (rises < r + 2 && n < 4000) begin
         @(negedge clk);
         n = n + 1;
      end
      chk("b2b_done", 32'(rises - r), 32'd2);
      if (acc_q.size() >= a + 2) begin
         chk("b2b_gap",  32'(acc_q[a + 1] - acc_q[a]), 32'd1537);
         chk("b2b_rise", 32'(rise_cyc - acc_q[a + 1]), 32'd1537);
      end
      chk("b2b_nwr", 32'(wa.size()), 32'd1024);
      ref_ksa(k);
      ref_ksa(k);
      check_mem("b2b_mem");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
